// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program image into memory, then runs and monitors the CPU
//
// Holds the CPU in reset while image words arrive on a valid/ready port and are
// written to the shared instruction/data memory. It then releases the CPU, counts
// run cycles, and stops the run on the halt instruction or when the cycle budget
// is used up.
//
// Ports
//   clk          single clock, all state on the rising edge
//   reset        synchronous, active-low
//   start        pulse; begins a load of load_len words (taken in IDLE/HALT only)
//   load_len     image word count, legal range 1..DEPTH, sampled with start
//   s_valid      image word valid
//   s_ready      loader accepts a word (high throughout LOAD)
//   s_data       image word
//   mem_we       memory write strobe
//   mem_addr     byte address of the write (word_index*4)
//   mem_wdata    word being written
//   cpu_reset    active-high reset to the CPU core
//   instr        instruction fetched by the CPU
//   halted       run finished (halt instruction or timeout)
//   timeout      run ended by the cycle budget
//   error        last start carried an illegal load_len
//   word_count   words written in the current load
//   cycle_count  cycles spent in RUN
module program_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] HALT_INSTR = 32'hE12FFF1E,
  parameter int          MAX_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [31:0]           s_data,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  input  logic [31:0]           instr,
  output logic                  halted,
  output logic                  timeout,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           cycle_count
);

  localparam int              CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0]   ONE   = CW'(1);
  localparam logic [31:0]     MAX_C = 32'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] len_q, len_d;
  logic          mem_we_d, cpu_reset_d, halted_d, timeout_d, error_d;
  logic [31:0]   mem_addr_d, mem_wdata_d, cycle_count_d;
  logic [CW-1:0] word_count_d;
  logic          legal_len;

  // s_ready is the only output decoded straight from state, so a word can be
  // accepted on the very first LOAD cycle.
  assign s_ready   = (state == S_LOAD);
  assign legal_len = (load_len != '0) && (load_len <= DEPTH);

  always_comb begin
    state_d       = state;
    len_d         = len_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    cpu_reset_d   = cpu_reset;
    halted_d      = halted;
    timeout_d     = timeout;
    error_d       = error;
    word_count_d  = word_count;
    cycle_count_d = cycle_count;

    case (state)
      S_IDLE, S_HALT: begin
        cpu_reset_d = 1'b1;
        if (start) begin
          if (legal_len) begin
            state_d       = S_LOAD;
            len_d         = load_len;
            word_count_d  = '0;
            error_d       = 1'b0;
            halted_d      = 1'b0;
            timeout_d     = 1'b0;
            cycle_count_d = '0;
          end else begin
            // An illegal request out of HALT also abandons the finished run.
            state_d  = S_IDLE;
            error_d  = 1'b1;
            halted_d = 1'b0;
          end
        end
      end

      S_LOAD: begin
        cpu_reset_d = 1'b1;
        if (s_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {{(32 - CW - 2){1'b0}}, word_count, 2'b00};
          mem_wdata_d = s_data;
          if (word_count != len_q) begin
            word_count_d = word_count + ONE;
          end
          if (word_count == len_q - ONE) begin
            state_d = S_RELEASE;
          end
        end
      end

      // One spare cycle so the final write is in memory before the CPU fetches.
      S_RELEASE: begin
        state_d       = S_RUN;
        cpu_reset_d   = 1'b0;
        cycle_count_d = 32'd1;
      end

      S_RUN: begin
        cpu_reset_d = 1'b0;
        if (instr == HALT_INSTR) begin
          state_d     = S_HALT;
          cpu_reset_d = 1'b1;
          halted_d    = 1'b1;
        end else if (cycle_count == MAX_C) begin
          state_d     = S_HALT;
          cpu_reset_d = 1'b1;
          halted_d    = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          cycle_count_d = cycle_count + 32'd1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cpu_reset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset   <= 1'b1;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      error       <= 1'b0;
      word_count  <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_d;
      len_q       <= len_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      cpu_reset   <= cpu_reset_d;
      halted      <= halted_d;
      timeout     <= timeout_d;
      error       <= error_d;
      word_count  <= word_count_d;
      cycle_count <= cycle_count_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed scoreboard bench for program_loader
//
// Drives loads, runs, halts, timeouts and illegal starts against a small
// instance (DEPTH=16, MAX_CYCLES=20). Expected memory writes are queued as words
// are handed over and retired when mem_we is seen.
//
// Ports: none (top-level bench).
module tb_program_loader;

  localparam int          AW   = 4;
  localparam int          CW   = AW + 1;
  localparam int          MAXC = 20;
  localparam logic [31:0] HALT = 32'hE12FFF1E;

  logic          clk = 1'b0;
  logic          reset, start, s_valid, s_ready, mem_we, cpu_reset;
  logic          halted, timeout, error;
  logic [CW-1:0] load_len, word_count;
  logic [31:0]   s_data, mem_addr, mem_wdata, instr, cycle_count;

  int            checks   = 0;
  int            failures = 0;
  int            idx      = 0;
  logic [63:0]   exp_q[$];

  program_loader #(
    .ADDR_WIDTH (AW),
    .HALT_INSTR (HALT),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_len    (load_len),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset   (cpu_reset),
    .instr       (instr),
    .halted      (halted),
    .timeout     (timeout),
    .error       (error),
    .word_count  (word_count),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] len);
    start    = 1'b1;
    load_len = len;
    idx      = 0;
    step();
    start    = 1'b0;
  endtask

  // One cycle on the stream port; a handshake queues the write it must produce.
  task automatic word(input logic v, input logic [31:0] d, input logic exp_ready);
    logic hs;
    s_valid = v;
    s_data  = d;
    check("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
    hs = v && exp_ready;
    if (hs) begin
      exp_q.push_back({32'(idx * 4), d});
      idx++;
    end
    step();
    s_valid = 1'b0;
    check("mem_we_after_cycle", {31'd0, mem_we}, {31'd0, hs});
  endtask

  // Write monitor: every strobe must match the oldest queued handshake.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("write_pending", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("mem_addr", mem_addr, e[63:32]);
        check("mem_wdata", mem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    load_len = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    instr    = '0;
    step();
    step();

    // Reset state
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    reset = 1'b1;
    step();
    check("idle_s_ready", {31'd0, s_ready}, 32'd0);

    // Reset in the middle of a load
    do_start(CW'(8));
    word(1'b1, 32'h0000_0011, 1'b1);
    word(1'b1, 32'h0000_0022, 1'b1);
    word(1'b1, 32'h0000_0033, 1'b1);
    check("midload_word_count", 32'(word_count), 32'd3);
    reset = 1'b0;
    step();
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    check("abort_word_count", 32'(word_count), 32'd0);
    check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("abort_s_ready", {31'd0, s_ready}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("abort_idle_s_ready", {31'd0, s_ready}, 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back load of 4 words, release, then halt instruction at cycle 7
    do_start(CW'(4));
    for (int i = 0; i < 4; i++) word(1'b1, 32'hA0 + 32'(i), 1'b1);
    check("release_s_ready", {31'd0, s_ready}, 32'd0);
    check("release_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("load4_word_count", 32'(word_count), 32'd4);
    step();
    check("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("run_first_cycle", cycle_count, 32'd1);
    check("run_mem_we", {31'd0, mem_we}, 32'd0);
    repeat (6) step();
    check("run_cycle7", cycle_count, 32'd7);
    check("run_not_halted", {31'd0, halted}, 32'd0);
    instr = HALT;
    step();
    instr = '0;
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_timeout", {31'd0, timeout}, 32'd0);
    check("halt_cycle_count", cycle_count, 32'd7);
    check("halt_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    step();
    check("halt_hold_count", cycle_count, 32'd7);

    // Reload from HALT with gapped stream, then run into the timeout
    do_start(CW'(3));
    check("reload_halted", {31'd0, halted}, 32'd0);
    check("reload_cycle_count", cycle_count, 32'd0);
    check("reload_word_count", 32'(word_count), 32'd0);
    word(1'b1, 32'h0000_00B0, 1'b1);
    word(1'b0, 32'h0, 1'b1);
    word(1'b1, 32'h0000_00B1, 1'b1);
    word(1'b0, 32'h0, 1'b1);
    word(1'b1, 32'h0000_00B2, 1'b1);
    word(1'b1, 32'h0000_00B3, 1'b0);
    check("gapped_word_count", 32'(word_count), 32'd3);
    check("gapped_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    for (int n = 0; n < 40 && halted !== 1'b1; n++) step();
    check("to_halted", {31'd0, halted}, 32'd1);
    check("to_timeout", {31'd0, timeout}, 32'd1);
    check("to_cycle_count", cycle_count, 32'(MAXC));
    check("to_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Illegal lengths
    do_start(CW'(0));
    check("len0_error", {31'd0, error}, 32'd1);
    check("len0_halted", {31'd0, halted}, 32'd0);
    check("len0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    word(1'b1, 32'h0000_00C0, 1'b0);
    do_start(CW'(17));
    check("len17_error", {31'd0, error}, 32'd1);
    check("len17_s_ready", {31'd0, s_ready}, 32'd0);

    // Full-depth load; start during LOAD is ignored
    do_start(CW'(16));
    check("depth_error_cleared", {31'd0, error}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        start    = 1'b1;
        load_len = '0;
      end
      word(1'b1, 32'h0000_0D00 + 32'(i), 1'b1);
      start = 1'b0;
    end
    check("depth_error", {31'd0, error}, 32'd0);
    check("depth_word_count", 32'(word_count), 32'd16);
    check("depth_s_ready", {31'd0, s_ready}, 32'd0);
    step();
    repeat (19) step();
    check("both_cycle20", cycle_count, 32'd20);
    check("both_not_halted", {31'd0, halted}, 32'd0);
    instr = HALT;
    step();
    instr = '0;
    check("both_halted", {31'd0, halted}, 32'd1);
    check("both_timeout", {31'd0, timeout}, 32'd0);
    check("both_cycle_count", cycle_count, 32'd20);
    step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
